// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    dmem_req;
    logic                    dmem_we;
    logic [ADDRESS_BITS-1:0] dmem_addr;
    logic [3:0]              dmem_be;
    logic [31:0]             dmem_wdata;
    logic                    dmem_ready;
    logic [31:0]             dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory stage: issues aligned loads/stores over a req/ready bus, extracts load data,
// and presents a registered writeback bundle; stalls upstream while a transaction is open.
module mem_access_stage #(
    parameter int ADDRESS_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [2:0]          ex_funct3,
    input  logic                ex_reg_write,
    input  logic [4:0]          ex_rd,
    input  logic [31:0]         ALU_result,
    input  logic [31:0]         ex_store_data,
    output logic                stall,
    mem_access_stage_if.master  dmem,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic [4:0]          wb_rd,
    output logic [31:0]         wb_data,
    output logic                mem_fault
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  r_state, w_state_n;
    logic                    r_req, w_req_n;
    logic                    r_we, w_we_n;
    logic [ADDRESS_BITS-1:0] r_addr, w_addr_n;
    logic [3:0]              r_be, w_be_n;
    logic [31:0]             r_wdata, w_wdata_n;
    logic [2:0]              r_funct3, w_funct3_n;
    logic [1:0]              r_lane, w_lane_n;
    logic [4:0]              r_rd, w_rd_n;
    logic                    r_reg_write, w_reg_write_n;
    logic                    r_wb_valid, w_wb_valid_n;
    logic                    r_wb_reg_write, w_wb_reg_write_n;
    logic [4:0]              r_wb_rd, w_wb_rd_n;
    logic [31:0]             r_wb_data, w_wb_data_n;
    logic                    r_mem_fault, w_mem_fault_n;

    logic                    w_mem_op;
    logic                    w_f3_legal;
    logic                    w_misaligned;
    logic                    w_fault;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [31:0]             w_shifted;
    logic [31:0]             w_load;

    assign stall           = (r_state == BUSY);
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign wb_valid        = r_wb_valid;
    assign wb_reg_write    = r_wb_reg_write;
    assign wb_rd           = r_wb_rd;
    assign wb_data         = r_wb_data;
    assign mem_fault       = r_mem_fault;

    assign w_mem_op = ex_mem_read | ex_mem_write;
    assign w_fault  = (ex_mem_read & ex_mem_write) | ~w_f3_legal | w_misaligned;

    // Access size comes from funct3[1:0]; funct3[2] only selects zero-extension on loads.
    always_comb begin
        w_f3_legal   = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = ex_store_data;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = ex_mem_read;
            default:                w_f3_legal = 1'b0;
        endcase
        case (ex_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALU_result[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_misaligned = ALU_result[0];
                w_be         = 4'b0011 << ALU_result[1:0];
                w_wdata      = {2{ex_store_data[15:0]}};
            end
            default: w_misaligned = |ALU_result[1:0];
        endcase
    end

    always_comb begin
        w_shifted = dmem.dmem_rdata >> {r_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_state_n        = r_state;
        w_req_n          = r_req;
        w_we_n           = r_we;
        w_addr_n         = r_addr;
        w_be_n           = r_be;
        w_wdata_n        = r_wdata;
        w_funct3_n       = r_funct3;
        w_lane_n         = r_lane;
        w_rd_n           = r_rd;
        w_reg_write_n    = r_reg_write;
        w_wb_valid_n     = 1'b0;
        w_wb_reg_write_n = 1'b0;
        w_wb_rd_n        = r_wb_rd;
        w_wb_data_n      = r_wb_data;
        w_mem_fault_n    = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex_valid && !w_mem_op) begin
                    w_wb_valid_n     = 1'b1;
                    w_wb_reg_write_n = ex_reg_write;
                    w_wb_rd_n        = ex_rd;
                    w_wb_data_n      = ALU_result;
                end else if (ex_valid && w_fault) begin
                    w_wb_valid_n  = 1'b1;
                    w_mem_fault_n = 1'b1;
                    w_wb_rd_n     = ex_rd;
                    w_wb_data_n   = ALU_result;
                end else if (ex_valid) begin
                    w_state_n     = BUSY;
                    w_req_n       = 1'b1;
                    w_we_n        = ex_mem_write;
                    w_addr_n      = ALU_result[ADDRESS_BITS+1:2];
                    w_be_n        = w_be;
                    w_wdata_n     = w_wdata;
                    w_funct3_n    = ex_funct3;
                    w_lane_n      = ALU_result[1:0];
                    w_rd_n        = ex_rd;
                    w_reg_write_n = ex_reg_write;
                end
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    w_state_n        = IDLE;
                    w_req_n          = 1'b0;
                    w_wb_valid_n     = 1'b1;
                    w_wb_rd_n        = r_rd;
                    w_wb_reg_write_n = r_we ? 1'b0 : r_reg_write;
                    w_wb_data_n      = r_we ? '0 : w_load;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_be           <= '0;
            r_wdata        <= '0;
            r_funct3       <= '0;
            r_lane         <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_mem_fault    <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_req          <= w_req_n;
            r_we           <= w_we_n;
            r_addr         <= w_addr_n;
            r_be           <= w_be_n;
            r_wdata        <= w_wdata_n;
            r_funct3       <= w_funct3_n;
            r_lane         <= w_lane_n;
            r_rd           <= w_rd_n;
            r_reg_write    <= w_reg_write_n;
            r_wb_valid     <= w_wb_valid_n;
            r_wb_reg_write <= w_wb_reg_write_n;
            r_wb_rd        <= w_wb_rd_n;
            r_wb_data      <= w_wb_data_n;
            r_mem_fault    <= w_mem_fault_n;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-arithmetic reference model.
module tb_mem_access_stage;
    localparam int AB = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ALU_result, ex_store_data;
    logic        stall, wb_valid, wb_reg_write, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage_if #(.ADDRESS_BITS(AB)) dmem_if ();

    mem_access_stage #(.ADDRESS_BITS(AB)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ALU_result(ALU_result), .ex_store_data(ex_store_data),
        .stall(stall), .dmem(dmem_if),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_fault(mem_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int unsigned delay;
        logic [4:0]  rd;
        logic        rw;
    } txn_t;

    // Reference model: access width in bytes and byte-lane arithmetic.
    function automatic int unsigned nbytes(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        return 4'(((32'd1 << nbytes(f3)) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (nbytes(f3) == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (nbytes(f3) == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned n = nbytes(f3);
        logic [31:0] mask = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        logic [31:0] v = (rdata >> (8 * (addr % 4))) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_legal(input logic rd_op, input logic wr_op,
                                     input logic [2:0] f3, input logic [31:0] addr);
        if (rd_op && wr_op) return 1'b0;
        if (rd_op && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr_op && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        return (addr % nbytes(f3)) == 0;
    endfunction

    task automatic drive_ex(input logic v, input logic r, input logic w, input logic [2:0] f3,
                            input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] sd);
        ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3;
        ex_reg_write = rw; ex_rd = rd; ALU_result = alu; ex_store_data = sd;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive_ex(0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0);
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({stall, dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_be} !== 7'd0)
            $display("FAIL reset_ctl: stall=%b req=%b we=%b be=%b, expected all 0",
                     stall, dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_be);
        else n_pass++;
        n_checks++;
        if (dmem_if.dmem_addr !== '0 || dmem_if.dmem_wdata !== 32'd0)
            $display("FAIL reset_bus: addr=%h wdata=%h, expected 0", dmem_if.dmem_addr, dmem_if.dmem_wdata);
        else n_pass++;
        n_checks++;
        if ({wb_valid, wb_reg_write, mem_fault, wb_rd} !== 8'd0 || wb_data !== 32'd0)
            $display("FAIL reset_wb: valid=%b rw=%b fault=%b rd=%0d data=%h, expected all 0",
                     wb_valid, wb_reg_write, mem_fault, wb_rd, wb_data);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_passthrough;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        for (int i = 0; i < 10; i++) begin
            alu = (i == 0) ? 32'h0000_1234 : $urandom;
            rd  = (i == 0) ? 5'd5 : 5'($urandom);
            rw  = (i == 0) ? 1'b1 : 1'($urandom);
            @(negedge clock);
            drive_ex(1, 0, 0, 3'($urandom), rw, rd, alu, $urandom);
            @(posedge clock);
            #1 ex_valid = 1'b0;
            @(negedge clock);
            n_checks++;
            if (wb_valid !== 1'b1 || wb_data !== alu || wb_rd !== rd || wb_reg_write !== rw
                || mem_fault !== 1'b0 || stall !== 1'b0 || dmem_if.dmem_req !== 1'b0)
                $display("FAIL passthru %0d: valid=%b data=%h rd=%0d rw=%b fault=%b stall=%b req=%b, expected 1 %h %0d %b 0 0 0",
                         i, wb_valid, wb_data, wb_rd, wb_reg_write, mem_fault, stall, dmem_if.dmem_req, alu, rd, rw);
            else n_pass++;
            @(negedge clock);
            n_checks++;
            if (wb_valid !== 1'b0)
                $display("FAIL idle_no_wb %0d: valid=%b, expected 0", i, wb_valid);
            else n_pass++;
        end
    endtask

    task automatic test_mem_ops;
        txn_t q[$];
        txn_t t;
        int unsigned pick;
        logic [31:0] exp_data;
        q.push_back('{0, 1, 3'd0, 32'h102, 32'hAABB_CCDD, 32'd0, 3, 5'd3, 1});
        q.push_back('{1, 0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 0, 5'd10, 1});
        q.push_back('{1, 0, 3'd4, 32'h103, 32'd0, 32'h80FF_0000, 1, 5'd11, 1});
        q.push_back('{1, 0, 3'd1, 32'h102, 32'd0, 32'h80FF_0000, 2, 5'd12, 1});
        for (int i = 0; i < 20; i++) begin
            t.wr_op = 1'($urandom);
            t.rd_op = ~t.wr_op;
            pick    = t.wr_op ? $urandom_range(0, 2) : $urandom_range(0, 4);
            t.f3    = (pick < 3) ? 3'(pick) : 3'(pick + 1);
            t.addr  = $urandom & ~(nbytes(t.f3) - 1);
            t.sd    = $urandom;
            t.rdata = $urandom;
            t.delay = $urandom_range(0, 3);
            t.rd    = 5'($urandom);
            t.rw    = 1'($urandom);
            q.push_back(t);
        end
        foreach (q[k]) begin
            t = q[k];
            @(negedge clock);
            drive_ex(1, t.rd_op, t.wr_op, t.f3, t.rw, t.rd, t.addr, t.sd);
            @(posedge clock);
            #1 drive_ex(0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0);
            for (int c = 0; c <= int'(t.delay); c++) begin
                @(negedge clock);
                n_checks++;
                if (dmem_if.dmem_req !== 1'b1 || stall !== 1'b1 || wb_valid !== 1'b0
                    || dmem_if.dmem_addr !== t.addr[AB+1:2] || dmem_if.dmem_we !== t.wr_op
                    || (t.wr_op && (dmem_if.dmem_be !== m_be(t.f3, t.addr)
                                    || dmem_if.dmem_wdata !== m_wdata(t.f3, t.sd))))
                    $display("FAIL mem_bus %0d cyc %0d: req=%b stall=%b wbv=%b addr=%h we=%b be=%b wdata=%h, expected 1 1 0 %h %b %b %h",
                             k, c, dmem_if.dmem_req, stall, wb_valid, dmem_if.dmem_addr, dmem_if.dmem_we,
                             dmem_if.dmem_be, dmem_if.dmem_wdata, t.addr[AB+1:2], t.wr_op,
                             m_be(t.f3, t.addr), m_wdata(t.f3, t.sd));
                else n_pass++;
                dmem_if.dmem_ready = (c == int'(t.delay));
                dmem_if.dmem_rdata = (c == int'(t.delay)) ? t.rdata : $urandom;
            end
            @(negedge clock);
            dmem_if.dmem_ready = 1'b0;
            exp_data = t.wr_op ? 32'd0 : m_load(t.f3, t.addr, t.rdata);
            n_checks++;
            if (wb_valid !== 1'b1 || mem_fault !== 1'b0 || stall !== 1'b0 || dmem_if.dmem_req !== 1'b0)
                $display("FAIL mem_done %0d: valid=%b fault=%b stall=%b req=%b, expected 1 0 0 0",
                         k, wb_valid, mem_fault, stall, dmem_if.dmem_req);
            else n_pass++;
            n_checks++;
            if (wb_data !== exp_data || wb_reg_write !== (t.rd_op & t.rw))
                $display("FAIL mem_wb %0d: data=%h rw=%b, expected %h %b",
                         k, wb_data, wb_reg_write, exp_data, t.rd_op & t.rw);
            else n_pass++;
            if (t.rd_op) begin
                n_checks++;
                if (wb_rd !== t.rd)
                    $display("FAIL load_rd %0d: rd=%0d, expected %0d", k, wb_rd, t.rd);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fault;
        logic        r, w, legal;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 13; i++) begin
            a = $urandom;
            r = 1'b1; w = 1'b0; f3 = 3'd2;
            case ((i == 0) ? 0 : $urandom_range(0, 4))
                0: begin
                    if (i == 0) a = 32'h101;
                    else if (a[1:0] == 2'b00) a = a | 32'd2;
                    w = (i != 0) && 1'($urandom); r = ~w;
                end
                1: begin
                    a = a | 32'd1;
                    w = 1'($urandom); r = ~w;
                    f3 = (!w && 1'($urandom)) ? 3'd5 : 3'd1;
                end
                2: f3 = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(6, 7));
                3: begin r = 1'b0; w = 1'b1; f3 = 3'($urandom_range(3, 7)); end
                default: begin w = 1'b1; f3 = 3'($urandom_range(0, 2)); a = a & ~32'd3; end
            endcase
            legal = m_legal(r, w, f3, a);
            @(negedge clock);
            drive_ex(1, r, w, f3, 1'b1, 5'($urandom), a, $urandom);
            @(posedge clock);
            #1 drive_ex(0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0);
            @(negedge clock);
            n_checks++;
            if (mem_fault !== !legal || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== a
                || dmem_if.dmem_req !== 1'b0 || stall !== 1'b0)
                $display("FAIL fault %0d (r=%b w=%b f3=%0d a=%h): fault=%b valid=%b rw=%b data=%h req=%b stall=%b, expected %b 1 0 %h 0 0",
                         i, r, w, f3, a, mem_fault, wb_valid, wb_reg_write, wb_data,
                         dmem_if.dmem_req, stall, !legal, a);
            else n_pass++;
            @(negedge clock);
            n_checks++;
            if (mem_fault !== 1'b0 || wb_valid !== 1'b0 || dmem_if.dmem_req !== 1'b0)
                $display("FAIL fault_pulse %0d: fault=%b valid=%b req=%b, expected 0 0 0",
                         i, mem_fault, wb_valid, dmem_if.dmem_req);
            else n_pass++;
        end
    endtask

    task automatic test_idle_ready;
        @(negedge clock);
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (wb_valid !== 1'b0 || dmem_if.dmem_req !== 1'b0 || stall !== 1'b0)
                $display("FAIL idle_ready %0d: valid=%b req=%b stall=%b, expected 0 0 0",
                         c, wb_valid, dmem_if.dmem_req, stall);
            else n_pass++;
        end
        dmem_if.dmem_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rdat = $urandom;
        logic [31:0] add_res = $urandom;
        logic        stall_seen, ready_given = 1'b0;
        int          wb_cyc[$];
        logic [4:0]  wb_rds[$];
        logic [31:0] wb_dat[$];
        @(negedge clock);
        drive_ex(1, 1, 0, 3'd2, 1, 5'd7, 32'h200, 32'd0);
        @(posedge clock);
        #1 drive_ex(1, 0, 0, 3'd0, 1, 5'd9, add_res, 32'd0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            if (wb_valid === 1'b1) begin
                wb_cyc.push_back(cyc); wb_rds.push_back(wb_rd); wb_dat.push_back(wb_data);
            end
            dmem_if.dmem_ready = (dmem_if.dmem_req === 1'b1) && cyc >= 1 && !ready_given;
            if (dmem_if.dmem_ready) begin
                dmem_if.dmem_rdata = rdat;
                ready_given = 1'b1;
            end
            stall_seen = stall;
            @(posedge clock);
            if (ex_valid && stall_seen !== 1'b1) #1 ex_valid = 1'b0;
        end
        dmem_if.dmem_ready = 1'b0;
        n_checks++;
        if (wb_cyc.size() != 2 || ex_valid !== 1'b0)
            $display("FAIL b2b_count: writebacks=%0d add_pending=%b, expected 2 0", wb_cyc.size(), ex_valid);
        else n_pass++;
        if (wb_cyc.size() == 2) begin
            n_checks++;
            if (wb_rds[0] !== 5'd7 || wb_dat[0] !== m_load(3'd2, 32'h200, rdat))
                $display("FAIL b2b_load: rd=%0d data=%h, expected 7 %h", wb_rds[0], wb_dat[0], rdat);
            else n_pass++;
            n_checks++;
            if (wb_rds[1] !== 5'd9 || wb_dat[1] !== add_res || wb_cyc[1] != wb_cyc[0] + 1)
                $display("FAIL b2b_add: rd=%0d data=%h gap=%0d, expected 9 %h 1",
                         wb_rds[1], wb_dat[1], wb_cyc[1] - wb_cyc[0], add_res);
            else n_pass++;
        end
    endtask

    task automatic test_reset_busy;
        @(negedge clock);
        drive_ex(1, 1, 0, 3'd2, 1, 5'd4, 32'h300, 32'd0);
        @(posedge clock);
        #1 drive_ex(0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0);
        @(negedge clock);
        n_checks++;
        if (dmem_if.dmem_req !== 1'b1 || stall !== 1'b1)
            $display("FAIL rst_busy_pre: req=%b stall=%b, expected 1 1", dmem_if.dmem_req, stall);
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        n_checks++;
        if (dmem_if.dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL rst_busy: req=%b stall=%b valid=%b, expected 0 0 0",
                     dmem_if.dmem_req, stall, wb_valid);
        else n_pass++;
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_checks++;
            if (wb_valid !== 1'b0 || dmem_if.dmem_req !== 1'b0)
                $display("FAIL rst_stray_ready %0d: valid=%b req=%b, expected 0 0", c, wb_valid, dmem_if.dmem_req);
            else n_pass++;
        end
        dmem_if.dmem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_mem_ops();
        test_fault();
        test_idle_ready();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the ALU in the RISC-V pipeline.
- Consumes the ALU result, either as a load/store effective address or as a pass-through result, and runs loads/stores against data memory through a req/ready handshake.
- Byte-lane aligns store data, extracts and extends load data, and presents a registered writeback bundle.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ADDRESS_BITS, 16, width of the word address driven to data memory (byte address bits [ADDRESS_BITS+1:2]).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- ex_valid  in  1  instruction present at stage input
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_reg_write  in  1  instruction writes rd
- ex_rd  in  5  destination register
- ALU_result  in  32  effective address (load/store) or result (others)
- ex_store_data  in  32  rs2 value for stores
- stall  out  1  upstream must hold its outputs
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDRESS_BITS  word address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_ready  in  1  request completed; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  writeback bundle valid (1-cycle pulse per instruction)
- wb_reg_write  out  1  write wb_data to wb_rd
- wb_rd  out  5  destination register
- wb_data  out  32  result/load data
- mem_fault  out  1  pulse with wb_valid: misaligned or illegal access

Behaviour:
- States: IDLE, BUSY. Reset (reset==0 at edge) → IDLE. All outputs are 0 after reset, and the captured request registers are cleared.
- stall = (state==BUSY), combinational. It stays high through the dmem_ready cycle.
- IDLE, ex_valid, no mem op: next edge wb_valid=1, wb_data=ALU_result, wb_rd=ex_rd, wb_reg_write=ex_reg_write. Latency 1.
- IDLE, ex_valid=0: wb_valid=0 next cycle.
- IDLE, legal aligned mem op: capture dmem_addr=ALU_result[ADDRESS_BITS+1:2], dmem_we, dmem_be, dmem_wdata, funct3, addr[1:0], rd, reg_write. dmem_req=1 from the next cycle, then → BUSY. wb_valid=0.
- BUSY: dmem_req and all dmem_* outputs are held stable until the cycle dmem_ready=1. On that edge: dmem_req→0, state→IDLE, wb_valid=1.
  - Load completion: wb_data=extracted load value, wb_reg_write=captured reg_write.
  - Store completion: wb_reg_write=0, wb_data=0.
- Minimum load/store latency: accept edge → req cycle → ready in that same cycle → wb_valid on the following edge.
- dmem_ready while in IDLE is ignored.
- Store lanes:
  - SB: be=0001<<a[1:0], wdata={4{d[7:0]}}.
  - SH: be=0011<<a[1:0], wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
- Load extraction (lane chosen by captured a[1:0]):
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- Fault conditions (no memory request issued):
  - W with a[1:0]≠00.
  - H/HU with a[0]=1.
  - funct3 ∉ {000,001,010,100,101} for loads.
  - funct3 ∉ {000,001,010} for stores.
  - ex_mem_read and ex_mem_write both set.
- Fault response: next edge wb_valid=1, mem_fault=1, wb_reg_write=0, wb_data=ALU_result (the faulting address). State stays IDLE.
- Reset mid-BUSY: the transaction is abandoned. dmem_req=0 after the reset edge, and no wb_valid is produced for it.

Test Plan:
- ALU_result=0x0000_1234, ex_reg_write=1, rd=5, no mem op → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall never high.
- SB, ALU_result=0x102, ex_store_data=0xAABBCCDD → dmem_addr=0x40, dmem_be=0100, dmem_wdata=0xDDDDDDDD, dmem_we=1; ready after 3 cycles → stall high all 4 BUSY cycles, wb_valid with wb_reg_write=0.
- LB at 0x103, dmem_rdata=0x80FF_0000 → wb_data=0xFFFF_FF80. LBU same → 0x0000_0080. LH at 0x102 → 0xFFFF_80FF.
- LW at 0x101 → no dmem_req, next cycle mem_fault=1, wb_valid=1, wb_reg_write=0, wb_data=0x101.
- Back-to-back: LW 0x200 followed by ADD held under stall → LW writeback cycle is followed by ADD writeback on the next cycle, and neither is lost or duplicated.
- reset=0 while BUSY with dmem_ready low → dmem_req=0, stall=0, wb_valid=0 next cycle. A later stray dmem_ready produces no writeback.
